dmem_dma: RTL and testbench
===========================

Name: dmem_dma

Overview:
- Initiator-side block for the single-port word-addressed data memory (combinational read, write on posedge clk when we=1).
- Copies a block of words from source to destination, or fills a block with a constant, using memory cycles the CPU would otherwise issue.
- Sits beside the CPU on the data-memory port behind a bus mux. It owns the port while busy=1, and the CPU side only drives start/abort.

Parameters:
- LEN_W, 16, width of the word-count field (max block = 2^LEN_W - 1 words).
- ADDR_W, 32, byte-address width of the memory port.

Ports:
- clk  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse, sampled in IDLE only
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_W  source byte address (copy only)
- dst_addr  in  ADDR_W  destination byte address
- len  in  LEN_W  number of words
- fill_data  in  32  fill pattern (fill only)
- abort  in  1  stop after the current cycle
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  misalignment error; sticky until the next accepted start
- words_done  out  LEN_W  count of committed writes in the current or last job
- mem_we  out  1  memory write enable
- mem_a  out  ADDR_W  memory byte address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, valid combinationally in the same cycle

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - busy, done, err, mem_we = 0; mem_a, mem_wd, words_done = 0.
  - Internal source/destination pointers, remaining count and data buffer = 0.
  - mem_we drops immediately, even mid-write.
- Port drive outside active states: in IDLE and DONE, mem_we=0, mem_a=0, mem_wd=0.
- States: IDLE, RD, WR, FILL, DONE.
- IDLE, start=1 at edge E:
  - Latch mode, src, dst, len, fill_data; clear err and words_done.
  - If misaligned (dst[1:0]!=0, or src[1:0]!=0 when mode=0): err=1, go to DONE. No memory access.
  - Else if len==0: go to DONE. No memory access.
  - Else go to RD (copy) or FILL (fill).
- RD (one cycle): mem_a=src_ptr, mem_we=0. At the edge, buffer<=mem_rd, src_ptr+=4, go to WR.
- WR (one cycle): mem_a=dst_ptr, mem_wd=buffer, mem_we=1. At the edge:
  - dst_ptr+=4, remaining-=1, words_done+=1.
  - Go to DONE if remaining was 1, else go to RD.
- FILL: mem_a=dst_ptr, mem_wd=fill data, mem_we=1. One word per cycle with the same pointer and count updates. Go to DONE after the last word.
- DONE (exactly one cycle): done=1, busy=1. Next state is IDLE.
- Latency from the accepting edge E:
  - Copy of N words: done asserted in cycle 2N+1 after E.
  - Fill of N words: done asserted in cycle N+1 after E.
  - len==0 or error: done asserted in cycle 1 after E.
- Pointer arithmetic: pointers are ADDR_W bits, increment by 4, wrap modulo 2^ADDR_W silently.
- Overlapping regions: copy is strictly forward. When dst>src and the regions overlap, the result is the defined forward-copy smear. No correction is made.
- Abort sampled high at an edge while in RD, WR or FILL:
  - A write driven in the cycle ending at that edge commits, and words_done counts it.
  - A read in that cycle is discarded.
  - Next state is DONE with err unchanged.
  - Abort is ignored in IDLE and DONE.
- Start is ignored while busy=1.
- Start and abort high together in IDLE: start wins.
- words_done holds its final value through IDLE until the next accepted start.
- All outputs are registered or decoded from state and registers only. There is no combinational path from mem_rd to any output.

Decomposition:
- Shared package dmem_dma_pkg:
  - enum dma_state_t {IDLE, RD, WR, FILL, DONE}
  - constants MODE_COPY=0, MODE_FILL=1, WORD_BYTES=4
- No sub-module. A single FSM plus datapath registers is the natural size.
- The bench instantiates the existing data memory as the responder.

Test Plan:
- Copy: preload mem[0..3]=0x11,0x22,0x33,0x44; start mode=0, src=0x00, dst=0x40, len=4 -> mem[16..19]=0x11..0x44, done exactly 9 cycles after the accepting edge, words_done=4, err=0.
- Fill: start mode=1, dst=0x80, len=3, fill_data=0xDEADBEEF -> mem[32..34]=0xDEADBEEF, mem[35] unchanged, done 4 cycles after accept, mem_we high exactly 3 cycles.
- Error and zero length: start with src=0x02, len=5 -> err=1, done next cycle, mem_we never high. Then start with valid addresses and len=0 -> err cleared, done next cycle, no write.
- Abort: copy len=8, assert abort at the edge ending the 2nd WR cycle -> words_done=2, only dst words 0-1 written, done next cycle, err=0.
- Reset mid-op: drop reset_n during a WR cycle of a fill -> mem_we falls without waiting for clk, all outputs 0. After release, a new start works normally.
- Overlap and wrap: mem[0..2]=A,B,C; copy src=0x0, dst=0x4, len=2 -> mem[1..2]=A,A. Fill dst=0xFFFFFFFC, len=2 -> mem_a sequence 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the data-memory DMA initiator.
package dmem_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FILL,
        DONE
    } dma_state_t;

    localparam logic MODE_COPY  = 1'b0;
    localparam logic MODE_FILL  = 1'b1;
    localparam int   WORD_BYTES = 4;

    // A job is rejected when the destination is not word aligned, or when a
    // copy reads from a source that is not word aligned.
    function automatic logic addr_misaligned(input logic       mode,
                                             input logic [1:0] src_lo,
                                             input logic [1:0] dst_lo);
        return (dst_lo != 2'b00) || ((mode == MODE_COPY) && (src_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_dma.sv
// Block copy / block fill engine driving the single-port data memory.
// Copy alternates one read cycle and one write cycle per word; fill writes
// one word per cycle. The memory port is decoded from state so it drops
// immediately when the asynchronous reset forces the state back to IDLE.
module dmem_dma
    import dmem_dma_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [31:0]       fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [31:0]       buf_q;
    logic [31:0]       fill_q;
    logic              err_q;
    logic [LEN_W-1:0]  words_q;
    logic              bad_addr;

    assign bad_addr = addr_misaligned(mode, src_addr[1:0], dst_addr[1:0]);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode; abort only matters in the three active states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_addr || (len == '0)) state_d = DONE;
                    else if (mode == MODE_FILL)  state_d = FILL;
                    else                         state_d = RD;
                end
            end
            RD:   state_d = abort ? DONE : WR;
            WR:   state_d = (abort || (rem_q == LEN_W'(1))) ? DONE : RD;
            FILL: state_d = (abort || (rem_q == LEN_W'(1))) ? DONE : FILL;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job parameters, pointers, read buffer and progress counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            buf_q     <= '0;
            fill_q    <= '0;
            err_q     <= 1'b0;
            words_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        src_ptr_q <= src_addr;
                        dst_ptr_q <= dst_addr;
                        rem_q     <= len;
                        fill_q    <= fill_data;
                        err_q     <= bad_addr;
                        words_q   <= '0;
                    end
                end
                RD: begin
                    // An aborted read is simply dropped.
                    if (!abort) begin
                        buf_q     <= mem_rd;
                        src_ptr_q <= src_ptr_q + STEP;
                    end
                end
                WR, FILL: begin
                    // The write in this cycle commits even when aborting.
                    dst_ptr_q <= dst_ptr_q + STEP;
                    rem_q     <= rem_q - LEN_W'(1);
                    words_q   <= words_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Status and memory port decoded from state and registers only.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        err    = err_q;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        unique case (state_q)
            RD: mem_a = src_ptr_q;
            WR: begin
                mem_we = 1'b1;
                mem_a  = dst_ptr_q;
                mem_wd = buf_q;
            end
            FILL: begin
                mem_we = 1'b1;
                mem_a  = dst_ptr_q;
                mem_wd = fill_q;
            end
            default: ;
        endcase
    end

    assign words_done = words_q;

endmodule

// File: tb/tb_dmem_dma.sv
// Scoreboard bench for dmem_dma with a 256-word behavioural data memory.
module tb_dmem_dma;

    localparam int LEN_W  = 16;
    localparam int ADDR_W = 32;

    typedef struct {
        int              at;
        logic            err;
        logic [LEN_W-1:0] wd;
    } done_exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic [31:0]       fill_data = '0;
    logic              abort = 1'b0;
    logic              busy, done, err, mem_we;
    logic [LEN_W-1:0]  words_done;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd, mem_rd;

    logic [31:0] mem [0:255] = '{default: 32'h0};
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_d = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    done_exp_t dq[$];
    wr_exp_t   wq[$];

    dmem_dma #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .err(err), .words_done(words_done), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-addressed memory; the DUT write port has priority over preloads.
    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) begin
        if (mem_we)     mem[mem_a[9:2]] <= mem_wd;
        else if (pl_we) mem[pl_idx] <= pl_d;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every memory write and every done pulse is matched against queues.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got a=%h d=%h, expected no write", mem_a, mem_wd);
            end else begin
                wr_exp_t w;
                w = wq.pop_front();
                if (mem_a !== w.a || mem_wd !== w.d) begin
                    errors++;
                    $display("FAIL write: got a=%h d=%h, expected a=%h d=%h", mem_a, mem_wd, w.a, w.d);
                end
            end
        end
        if (done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                done_exp_t e;
                e = dq.pop_front();
                if (cyc != e.at || err !== e.err || words_done !== e.wd) begin
                    errors++;
                    $display("FAIL done: got cyc=%0d err=%b wd=%0d, expected cyc=%0d err=%b wd=%0d",
                             cyc, err, words_done, e.at, e.err, e.wd);
                end
            end
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_d = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wq.push_back('{a: a, d: d});
    endtask

    // Drive one start; leaves the bench on the negedge after the accepting edge.
    task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] l, input logic [31:0] f, input int hold,
                         input logic ab, input logic exp_done, input int lat,
                         input logic e_err, input logic [15:0] e_wd);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
        start = 1'b1; abort = ab;
        if (exp_done) dq.push_back('{at: cyc + lat, err: e_err, wd: e_wd});
        @(negedge clk);
        abort = 1'b0;
        if (hold > 1) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (dq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(dq.size()), 32'd0);
        chk({name, "_missing_writes"}, 32'(wq.size()), 32'd0);
        dq.delete();
        wq.delete();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_a", mem_a, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_words", 32'(words_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Copy 4 words 0x00 -> 0x40
        preload(8'd0, 32'h11); preload(8'd1, 32'h22);
        preload(8'd2, 32'h33); preload(8'd3, 32'h44);
        expect_wr(32'h40, 32'h11); expect_wr(32'h44, 32'h22);
        expect_wr(32'h48, 32'h33); expect_wr(32'h4C, 32'h44);
        issue(1'b0, 32'h0, 32'h40, 16'd4, 32'h0, 1, 1'b0, 1'b1, 9, 1'b0, 16'd4);
        wait_done("copy");
        chk("copy_mem16", mem[16], 32'h11);
        chk("copy_mem19", mem[19], 32'h44);
        repeat (3) @(negedge clk);
        chk("copy_words_hold", 32'(words_done), 32'd4);
        chk("copy_idle_busy", 32'(busy), 32'd0);

        // Fill 3 words at 0x80, start held into the busy period
        preload(8'd35, 32'h12345678);
        expect_wr(32'h80, 32'hDEADBEEF); expect_wr(32'h84, 32'hDEADBEEF);
        expect_wr(32'h88, 32'hDEADBEEF);
        issue(1'b1, 32'h0, 32'h80, 16'd3, 32'hDEADBEEF, 2, 1'b0, 1'b1, 4, 1'b0, 16'd3);
        wait_done("fill");
        chk("fill_mem34", mem[34], 32'hDEADBEEF);
        chk("fill_mem35", mem[35], 32'h12345678);

        // Misaligned source
        issue(1'b0, 32'h2, 32'h100, 16'd5, 32'h0, 1, 1'b0, 1'b1, 1, 1'b1, 16'd0);
        wait_done("misalign");
        repeat (2) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);

        // Zero length clears err, no writes
        issue(1'b0, 32'h0, 32'h100, 16'd0, 32'h0, 1, 1'b0, 1'b1, 1, 1'b0, 16'd0);
        wait_done("len0");
        chk("len0_err", 32'(err), 32'd0);

        // Abort at the edge ending the second WR cycle
        expect_wr(32'h200, 32'h11); expect_wr(32'h204, 32'h22);
        issue(1'b0, 32'h0, 32'h200, 16'd8, 32'h0, 1, 1'b0, 1'b1, 5, 1'b0, 16'd2);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort");
        chk("abort_mem129", mem[129], 32'h22);
        chk("abort_mem130", mem[130], 32'h0);

        // Asynchronous reset during the second FILL write
        expect_wr(32'h300, 32'hCAFEF00D);
        issue(1'b1, 32'h0, 32'h300, 16'd4, 32'hCAFEF00D, 1, 1'b0, 1'b0, 0, 1'b0, 16'd0);
        @(posedge clk);
        #2;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_a", mem_a, 32'd0);
        chk("mid_rst_wd", mem_wd, 32'd0);
        chk("mid_rst_words", 32'(words_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_wr_q", 32'(wq.size()), 32'd0);
        chk("rst_mem192", mem[192], 32'hCAFEF00D);
        chk("rst_mem193", mem[193], 32'h0);
        expect_wr(32'h300, 32'h0BADF00D);
        issue(1'b1, 32'h0, 32'h300, 16'd1, 32'h0BADF00D, 1, 1'b0, 1'b1, 2, 1'b0, 16'd1);
        wait_done("after_rst");

        // Forward overlapping copy, start and abort together in IDLE
        preload(8'd0, 32'hAAAA0001); preload(8'd1, 32'hBBBB0002); preload(8'd2, 32'hCCCC0003);
        expect_wr(32'h4, 32'hAAAA0001); expect_wr(32'h8, 32'hAAAA0001);
        issue(1'b0, 32'h0, 32'h4, 16'd2, 32'h0, 1, 1'b1, 1'b1, 5, 1'b0, 16'd2);
        wait_done("overlap");
        chk("overlap_mem1", mem[1], 32'hAAAA0001);
        chk("overlap_mem2", mem[2], 32'hAAAA0001);

        // Destination pointer wraps past the top of the address space
        expect_wr(32'hFFFFFFFC, 32'h5555AAAA); expect_wr(32'h0, 32'h5555AAAA);
        issue(1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'h5555AAAA, 1, 1'b0, 1'b1, 3, 1'b0, 16'd2);
        wait_done("wrap");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
